// File: rtl/crc_scheduler.sv
// Round-robin front end that shares one CRC engine between NUM_REQ parser lanes,
// with one job in flight, a hang timeout that drains late completions, and job counters.
module crc_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int CRC_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [CRC_W-1:0]          resp_crc,
    output logic                      resp_err,
    output logic                      crc_valid,
    output logic [DATA_W-1:0]         crc_data,
    input  logic                      crc_done,
    input  logic [CRC_W-1:0]          crc_result,
    output logic                      busy,
    output logic [CNT_W-1:0]          stat_jobs,
    output logic [CNT_W-1:0]          stat_timeouts
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             win_found;
    logic [TMR_W-1:0] timer;

    // Scan starts just past the previous winner so every lane gets a turn before any repeats.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign req_ready = (state == IDLE && !rst && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            grant         <= '0;
            timer         <= '0;
            resp_valid    <= '0;
            resp_crc      <= '0;
            resp_err      <= 1'b0;
            crc_valid     <= 1'b0;
            crc_data      <= '0;
            stat_jobs     <= '0;
            stat_timeouts <= '0;
        end else begin
            crc_valid  <= 1'b0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant     <= win_idx;
                        crc_data  <= req_data[win_idx*DATA_W +: DATA_W];
                        crc_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                // A completion in the final timer cycle still counts as success.
                WAIT: begin
                    if (crc_done) begin
                        resp_crc   <= crc_result;
                        resp_err   <= 1'b0;
                        resp_valid <= NUM_REQ'(1) << grant;
                        state      <= RESP;
                    end else if (timer == TMR_LAST) begin
                        resp_crc   <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= NUM_REQ'(1) << grant;
                        state      <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    resp_crc   <= '0;
                    resp_err   <= 1'b0;
                    if (resp_err) begin
                        if (stat_timeouts != '1) stat_timeouts <= stat_timeouts + 1'b1;
                        timer <= '0;
                        state <= DRAIN;
                    end else begin
                        if (stat_jobs != '1) stat_jobs <= stat_jobs + 1'b1;
                        state <= IDLE;
                    end
                end
                // Swallow a late completion so it cannot be credited to the next job.
                DRAIN: begin
                    if (crc_done || timer == TMR_LAST) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_scheduler.sv
// Randomized scoreboard bench for crc_scheduler: a stub engine with per-job latency,
// a round-robin/latency reference model feeding queues, and a monitor that pops on each response.
module tb_crc_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 256;
    localparam int CRC_W   = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [CRC_W-1:0]          resp_crc;
    logic                      resp_err;
    logic                      crc_valid;
    logic [DATA_W-1:0]         crc_data;
    logic                      crc_done;
    logic [CRC_W-1:0]          crc_result;
    logic                      busy;
    logic [CNT_W-1:0]          stat_jobs;
    logic [CNT_W-1:0]          stat_timeouts;

    typedef struct {
        int          req;
        logic [31:0] crc;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } issue_t;

    resp_t  exp_q[$];
    issue_t iss_q[$];
    int     lat_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    int m_last;
    int m_idle;
    int m_jobs;
    int m_tos;

    crc_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CRC_W(CRC_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_crc(resp_crc), .resp_err(resp_err),
        .crc_valid(crc_valid), .crc_data(crc_data),
        .crc_done(crc_done), .crc_result(crc_result),
        .busy(busy), .stat_jobs(stat_jobs), .stat_timeouts(stat_timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Stub engine: returns the low word of the block after the latency queued for that job.
    initial begin
        int cnt;
        bit pend;
        logic [31:0] res;
        int lat;
        crc_done   = 1'b0;
        crc_result = '0;
        pend       = 1'b0;
        cnt        = 0;
        res        = '0;
        forever begin
            @(posedge clk);
            #1;
            crc_done   = 1'b0;
            crc_result = $urandom;
            if (rst) begin
                pend = 1'b0;
            end else if (crc_valid) begin
                lat  = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                pend = (lat != 0);
                cnt  = lat;
                res  = crc_data[31:0];
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    crc_done   = 1'b1;
                    crc_result = res;
                    pend       = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every engine start and every response against the queues.
    initial begin
        resp_t  e;
        issue_t s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (resp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("resp_unexpected", DATA_W'(resp_valid), '0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("resp_valid", DATA_W'(resp_valid), DATA_W'(NUM_REQ'(1) << e.req));
                        checkOutput("resp_crc", DATA_W'(resp_crc), DATA_W'(e.crc));
                        checkOutput("resp_err", DATA_W'(resp_err), DATA_W'(e.err));
                        checkOutput("resp_cycle", DATA_W'(cycle), DATA_W'(e.cyc));
                    end
                end
                if (crc_valid) begin
                    if (iss_q.size() == 0) begin
                        checkOutput("issue_unexpected", DATA_W'(crc_valid), '0);
                    end else begin
                        s = iss_q.pop_front();
                        checkOutput("issue_cycle", DATA_W'(cycle), DATA_W'(s.cyc));
                        checkOutput("issue_data", crc_data, s.data);
                    end
                end
            end
        end
    end

    // Offers a request pattern, checks grant and accept time, and queues the predicted outcome.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] pat, input int lat);
        int win;
        int idx;
        int n;
        int acc;
        int predicted;
        resp_t  e;
        issue_t s;
        logic [DATA_W-1:0] d;
        req_valid = pat;
        win = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (m_last + k) % NUM_REQ;
            if (win < 0 && pat[idx]) win = idx;
        end
        #1;
        predicted = (m_idle > cycle) ? m_idle : cycle;
        n = 0;
        while (req_ready == '0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_ready == '0) begin
            checkOutput("accept_timeout", DATA_W'(req_ready), DATA_W'(NUM_REQ'(1) << win));
            req_valid = '0;
            return;
        end
        acc = cycle;
        checkOutput("req_ready", DATA_W'(req_ready), DATA_W'(NUM_REQ'(1) << win));
        checkOutput("accept_cycle", DATA_W'(acc), DATA_W'(predicted));
        d     = req_data[win*DATA_W +: DATA_W];
        e.req = win;
        if (lat != 0 && lat <= TIMEOUT) begin
            e.crc  = d[31:0];
            e.err  = 1'b0;
            e.cyc  = acc + lat + 2;
            m_idle = acc + lat + 3;
            m_jobs++;
        end else begin
            e.crc  = '0;
            e.err  = 1'b1;
            e.cyc  = acc + 2 + TIMEOUT;
            m_idle = (lat >= TIMEOUT + 2 && lat <= 2 * TIMEOUT + 1) ? acc + 2 + lat
                                                                   : acc + 3 + 2 * TIMEOUT;
            m_tos++;
        end
        s.cyc  = acc + 1;
        s.data = d;
        exp_q.push_back(e);
        iss_q.push_back(s);
        lat_q.push_back(lat);
        m_last = win;
        @(negedge clk);
        #1;
        checkOutput("busy_active", DATA_W'(busy), DATA_W'(1));
        req_data[win*DATA_W +: DATA_W] = rand256();
        req_valid = '0;
    endtask

    task automatic waitQuiet();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resp_missing", DATA_W'(exp_q.size()), '0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic checkStats();
        checkOutput("stat_jobs", DATA_W'(stat_jobs), DATA_W'(m_jobs));
        checkOutput("stat_timeouts", DATA_W'(stat_timeouts), DATA_W'(m_tos));
    endtask

    task automatic checkReset();
        checkOutput("rst_req_ready", DATA_W'(req_ready), '0);
        checkOutput("rst_resp_valid", DATA_W'(resp_valid), '0);
        checkOutput("rst_resp_crc", DATA_W'(resp_crc), '0);
        checkOutput("rst_resp_err", DATA_W'(resp_err), '0);
        checkOutput("rst_crc_valid", DATA_W'(crc_valid), '0);
        checkOutput("rst_crc_data", crc_data, '0);
        checkOutput("rst_busy", DATA_W'(busy), '0);
        checkOutput("rst_stat_jobs", DATA_W'(stat_jobs), '0);
        checkOutput("rst_stat_timeouts", DATA_W'(stat_timeouts), '0);
    endtask

    task automatic applyReset();
        rst       = 1'b1;
        req_valid = '0;
        exp_q.delete();
        iss_q.delete();
        lat_q.delete();
        @(negedge clk);
        checkReset();
        rst    = 1'b0;
        m_last = NUM_REQ - 1;
        m_jobs = 0;
        m_tos  = 0;
        #1;
        m_idle = cycle;
    endtask

    initial begin
        logic [NUM_REQ-1:0] pat;
        int lat;
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = rand256();
        repeat (3) @(negedge clk);
        #1;
        applyReset();

        $display("[TB] single job");
        req_data[31:0] = 32'h4B5A6978;
        applyStimulus(4'b0001, 3);
        waitQuiet();
        checkStats();

        $display("[TB] fairness with all lanes requesting");
        for (int j = 0; j < 8; j++) applyStimulus(4'b1111, 1 + int'($urandom_range(0, 5)));
        applyStimulus(4'b1000, 2);
        $display("[TB] sparse wrap");
        applyStimulus(4'b0110, 3);
        applyStimulus(4'b0110, 3);

        $display("[TB] timeouts, drain and tie");
        applyStimulus(4'b0100, 0);
        applyStimulus(4'b0001, 3);
        applyStimulus(4'b0010, TIMEOUT + 10);
        applyStimulus(4'b1000, 4);
        applyStimulus(4'b0001, TIMEOUT);
        applyStimulus(4'b0010, TIMEOUT + 1);
        applyStimulus(4'b0100, 2);
        waitQuiet();
        checkStats();

        $display("[TB] reset during WAIT");
        applyStimulus(4'b0010, 20);
        repeat (5) @(negedge clk);
        #1;
        applyReset();
        repeat (25) @(negedge clk);
        #1;
        applyStimulus(4'b1111, 3);
        waitQuiet();
        checkStats();

        $display("[TB] randomized traffic");
        for (int j = 0; j < 30; j++) begin
            pat = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            applyStimulus(pat, lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) @(negedge clk);
            #1;
        end
        waitQuiet();
        checkStats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/crc_scheduler.md
# crc_scheduler

Shares one CRC engine (256-bit block in, 32-bit CRC out, `valid`/`done` pulses) between NUM_REQ packet-parser requesters. Round-robin arbitration, one job in flight, results routed back to the granted requester, engine-hang timeout with drain, and saturating status counters. Sits between the parser lanes and the CRC engine instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 256: block width sent to engine
- CRC_W, 32: CRC result width
- TIMEOUT, 64: max WAIT/DRAIN cycles before giving up (≥2)
- CNT_W, 16: status counter width

- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester job request
- req_data  in  NUM_REQ*DATA_W  flattened; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot accept; handshake = req_valid[i] & req_ready[i]
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
- resp_crc  out  CRC_W  result; valid only with resp_valid
- resp_err  out  1  timeout flag; valid only with resp_valid
- crc_valid  out  1  one-cycle start pulse to engine
- crc_data  out  DATA_W  block to engine, held stable from ISSUE until next accept
- crc_done  in  1  engine completion pulse
- crc_result  in  CRC_W  engine result, sampled with crc_done
- busy  out  1  high in any state except IDLE
- stat_jobs  out  CNT_W  completed jobs (saturating)
- stat_timeouts  out  CNT_W  timed-out jobs (saturating)

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: if any req_valid, winner = first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap. req_ready[winner]=1 combinationally that cycle; data latched into crc_data register, grant id stored, -> ISSUE. No request: stay.
- ISSUE: crc_valid=1 for exactly this cycle; timer cleared; -> WAIT.
- WAIT: on crc_done, capture crc_result, err=0, -> RESP. Else timer++; when timer reaches TIMEOUT-1 without crc_done, result=0, err=1, -> RESP.
- RESP: resp_valid[grant]=1, resp_crc/resp_err driven from capture register; last_grant<=grant; stat_jobs++ (err=0) or stat_timeouts++ (err=1), saturating at all-ones. err=0 -> IDLE; err=1 -> DRAIN with timer cleared.
- DRAIN: absorbs a late crc_done (discarded) or waits TIMEOUT cycles, whichever first, then -> IDLE. Prevents late result being attributed to next job.
- crc_done outside WAIT/DRAIN is ignored.
- Requesters must take resp_valid the cycle it is high; no response backpressure.
- req_valid may drop while not granted; no state retained for ungranted requesters.

## Timing
- Reset (sync, any state, mid-job included): state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), req_ready=0 except IDLE combinational grant once rst low, resp_valid=0, resp_crc=0, resp_err=0, crc_valid=0, crc_data=0, busy=0, both counters=0. In-flight job dropped, no response issued.
- Accept in cycle T; crc_valid in T+1; crc_done seen in cycle X (≥T+2) -> resp_valid in X+1; next accept earliest X+2.
- Engine latency L (crc_valid to crc_done) gives accept-to-response latency L+2, job period L+3.
- Timeout: crc_done absent -> resp_valid with err=1 at T+2+TIMEOUT.
- crc_done in the same cycle timer hits TIMEOUT-1: done wins, err=0.
- At most one req_ready bit high; never high outside IDLE.

## Test plan
- Single job: stub engine L=3 returns crc_data[31:0]; req_valid[0] with data low word 32'h4B5A6978 -> req_ready[0] same cycle, crc_valid 1 cycle later, resp_valid=4'b0001, resp_crc=32'h4B5A6978, err=0 five cycles after accept; stat_jobs=1.
- Fairness: all four req_valid held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3; no requester granted twice before others.
- Sparse wrap: last_grant=3, only req 2 and 1 valid -> 1 granted, then 2.
- Timeout: stub never asserts done, TIMEOUT=64 -> resp err=1, resp_crc=0 at accept+66; stat_timeouts=1; late done in DRAIN discarded, next job returns its own CRC.
- Tie: done arrives exactly at timer TIMEOUT-1 -> err=0, correct CRC.
- Reset mid-WAIT: rst for one cycle -> all outputs zero next cycle, no resp_valid for dropped job, counters 0, requester 0 wins next arbitration.
